// File: rtl/alu_operand_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_pkg
//  Shared constants for the ID->EX operand stage: operand-select encodings
//  and default datapath widths.
// ---------------------------------------------------------------------------
package alu_operand_pkg;

   // Default widths
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_REG_ADDR_W = 5;
   localparam int DEF_ALU_OP_W   = 4;

   // Fixed instruction field widths
   localparam int IMM_W   = 16;
   localparam int SHAMT_W = 5;

   // Left-operand select
   localparam logic       SEL_LHS_RS = 1'b0;
   localparam logic       SEL_LHS_RT = 1'b1;

   // Right-operand select
   localparam logic [1:0] SEL_RHS_RS    = 2'b00;
   localparam logic [1:0] SEL_RHS_RT    = 2'b01;
   localparam logic [1:0] SEL_RHS_SHAMT = 2'b10;
   localparam logic [1:0] SEL_RHS_IMM   = 2'b11;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
//  Three-way forwarding select for one source operand.
//  Priority: EX/MEM result, then MEM/WB result, then register-file data.
//  Register $0 is hard-wired to zero in the register file, so it is never
//  forwarded even if a later stage claims to write it.
//
//  Ports:
//   w_src_addr   in  source register index
//   w_rf_data    in  register-file read data
//   w_exm_*      in  EX/MEM write enable / address / data
//   w_mwb_*      in  MEM/WB write enable / address / data
//   w_fwd_data   out resolved operand value
// ---------------------------------------------------------------------------
module fwd_mux
   import alu_operand_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] w_src_addr,
   input  logic [DATA_W-1:0]     w_rf_data,
   input  logic                  w_exm_wr_en,
   input  logic [REG_ADDR_W-1:0] w_exm_wr_addr,
   input  logic [DATA_W-1:0]     w_exm_wr_data,
   input  logic                  w_mwb_wr_en,
   input  logic [REG_ADDR_W-1:0] w_mwb_wr_addr,
   input  logic [DATA_W-1:0]     w_mwb_wr_data,
   output logic [DATA_W-1:0]     w_fwd_data
);

   logic w_src_nonzero;
   logic w_hit_exm;
   logic w_hit_mwb;

   assign w_src_nonzero = (w_src_addr != '0);
   assign w_hit_exm     = w_exm_wr_en & (w_exm_wr_addr == w_src_addr) & w_src_nonzero;
   assign w_hit_mwb     = w_mwb_wr_en & (w_mwb_wr_addr == w_src_addr) & w_src_nonzero;

   always_comb begin
      w_fwd_data = w_rf_data;
      if (w_hit_exm)      w_fwd_data = w_exm_wr_data;
      else if (w_hit_mwb) w_fwd_data = w_mwb_wr_data;
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//  ID->EX pipeline register. Resolves forwarding on rs/rt, extends the
//  immediate and shift amount, applies the ALU operand muxes and registers
//  lhs/rhs, store data, opcode and destination for the EX stage.
//
//  Handshake: w_in_ready = ~w_stall. An instruction is accepted on a rising
//  edge when w_in_valid & w_in_ready & ~w_flush; w_out_valid marks a valid
//  instruction held in the register. Flush beats stall beats load.
//
//  Ports:
//   w_clk, w_reset_n          clock, async active-low reset
//   w_in_valid/w_stall/w_flush pipeline control
//   w_rs_*/w_rt_*             source indices and register-file data
//   w_imm16/w_imm_zext/w_shamt immediate fields
//   w_alu_lhs_ctrl/_rhs_ctrl  operand selects
//   w_alu_op/w_dest_addr      pass-through opcode and writeback index
//   w_exm_*/w_mwb_*           forwarding sources
//   w_in_ready                combinational ready to decode
//   w_out_valid, w_alu_lhs, w_alu_rhs, w_store_data, w_alu_op_q,
//   w_dest_addr_q             registered EX-stage outputs
// ---------------------------------------------------------------------------
module alu_operand_stage
   import alu_operand_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int REG_ADDR_W = DEF_REG_ADDR_W,
   parameter int ALU_OP_W   = DEF_ALU_OP_W
) (
   input  logic                  w_clk,
   input  logic                  w_reset_n,
   input  logic                  w_in_valid,
   input  logic                  w_stall,
   input  logic                  w_flush,
   input  logic [REG_ADDR_W-1:0] w_rs_addr,
   input  logic [REG_ADDR_W-1:0] w_rt_addr,
   input  logic [DATA_W-1:0]     w_rs_data,
   input  logic [DATA_W-1:0]     w_rt_data,
   input  logic [IMM_W-1:0]      w_imm16,
   input  logic                  w_imm_zext,
   input  logic [SHAMT_W-1:0]    w_shamt,
   input  logic                  w_alu_lhs_ctrl,
   input  logic [1:0]            w_alu_rhs_ctrl,
   input  logic [ALU_OP_W-1:0]   w_alu_op,
   input  logic [REG_ADDR_W-1:0] w_dest_addr,
   input  logic                  w_exm_wr_en,
   input  logic [REG_ADDR_W-1:0] w_exm_wr_addr,
   input  logic [DATA_W-1:0]     w_exm_wr_data,
   input  logic                  w_mwb_wr_en,
   input  logic [REG_ADDR_W-1:0] w_mwb_wr_addr,
   input  logic [DATA_W-1:0]     w_mwb_wr_data,
   output logic                  w_in_ready,
   output logic                  w_out_valid,
   output logic [DATA_W-1:0]     w_alu_lhs,
   output logic [DATA_W-1:0]     w_alu_rhs,
   output logic [DATA_W-1:0]     w_store_data,
   output logic [ALU_OP_W-1:0]   w_alu_op_q,
   output logic [REG_ADDR_W-1:0] w_dest_addr_q
);

   logic [DATA_W-1:0] w_fwd_rs;
   logic [DATA_W-1:0] w_fwd_rt;
   logic [DATA_W-1:0] w_imm_ext;
   logic [DATA_W-1:0] w_shamt_ext;
   logic [DATA_W-1:0] w_lhs_sel;
   logic [DATA_W-1:0] w_rhs_sel;

   logic                  r_valid;
   logic [DATA_W-1:0]     r_lhs;
   logic [DATA_W-1:0]     r_rhs;
   logic [DATA_W-1:0]     r_store;
   logic [ALU_OP_W-1:0]   r_op;
   logic [REG_ADDR_W-1:0] r_dest;

   fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
      .w_src_addr    (w_rs_addr),
      .w_rf_data     (w_rs_data),
      .w_exm_wr_en   (w_exm_wr_en),
      .w_exm_wr_addr (w_exm_wr_addr),
      .w_exm_wr_data (w_exm_wr_data),
      .w_mwb_wr_en   (w_mwb_wr_en),
      .w_mwb_wr_addr (w_mwb_wr_addr),
      .w_mwb_wr_data (w_mwb_wr_data),
      .w_fwd_data    (w_fwd_rs)
   );

   fwd_mux #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
      .w_src_addr    (w_rt_addr),
      .w_rf_data     (w_rt_data),
      .w_exm_wr_en   (w_exm_wr_en),
      .w_exm_wr_addr (w_exm_wr_addr),
      .w_exm_wr_data (w_exm_wr_data),
      .w_mwb_wr_en   (w_mwb_wr_en),
      .w_mwb_wr_addr (w_mwb_wr_addr),
      .w_mwb_wr_data (w_mwb_wr_data),
      .w_fwd_data    (w_fwd_rt)
   );

   // Logical ops take a zero-extended immediate, arithmetic ops sign-extend.
   assign w_imm_ext   = w_imm_zext ? {{(DATA_W-IMM_W){1'b0}}, w_imm16}
                                   : {{(DATA_W-IMM_W){w_imm16[IMM_W-1]}}, w_imm16};
   assign w_shamt_ext = {{(DATA_W-SHAMT_W){1'b0}}, w_shamt};

   assign w_lhs_sel = (w_alu_lhs_ctrl == SEL_LHS_RT) ? w_fwd_rt : w_fwd_rs;

   always_comb begin
      w_rhs_sel = w_fwd_rs;
      case (w_alu_rhs_ctrl)
         SEL_RHS_RS:    w_rhs_sel = w_fwd_rs;
         SEL_RHS_RT:    w_rhs_sel = w_fwd_rt;
         SEL_RHS_SHAMT: w_rhs_sel = w_shamt_ext;
         SEL_RHS_IMM:   w_rhs_sel = w_imm_ext;
         default:       w_rhs_sel = w_fwd_rs;
      endcase
   end

   // Flush clears even while stalled; a load with no valid instruction
   // writes a clean bubble so stale payload never reaches EX.
   always_ff @(posedge w_clk or negedge w_reset_n) begin
      if (!w_reset_n) begin
         r_valid <= 1'b0;
         r_lhs   <= '0;
         r_rhs   <= '0;
         r_store <= '0;
         r_op    <= '0;
         r_dest  <= '0;
      end else if (w_flush) begin
         r_valid <= 1'b0;
         r_lhs   <= '0;
         r_rhs   <= '0;
         r_store <= '0;
         r_op    <= '0;
         r_dest  <= '0;
      end else if (!w_stall) begin
         r_valid <= w_in_valid;
         r_lhs   <= w_in_valid ? w_lhs_sel   : '0;
         r_rhs   <= w_in_valid ? w_rhs_sel   : '0;
         r_store <= w_in_valid ? w_fwd_rt    : '0;
         r_op    <= w_in_valid ? w_alu_op    : '0;
         r_dest  <= w_in_valid ? w_dest_addr : '0;
      end
   end

   assign w_in_ready    = ~w_stall;
   assign w_out_valid   = r_valid;
   assign w_alu_lhs     = r_lhs;
   assign w_alu_rhs     = r_rhs;
   assign w_store_data  = r_store;
   assign w_alu_op_q    = r_op;
   assign w_dest_addr_q = r_dest;

endmodule
